// File: rtl/clk_enable_gen_if.sv
// Configuration and enable-output bundle for clk_enable_gen.
// The master drives configuration and resync; the slave (the generator) drives ce and running.
interface clk_enable_gen_if #(
  parameter int CHANNELS = 4,
  parameter int ACC_W    = 32
);
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                cfg_we;
  logic [SEL_W-1:0]    cfg_sel;
  logic [ACC_W-1:0]    cfg_inc;
  logic [ACC_W-1:0]    cfg_phase;
  logic                resync;
  logic [CHANNELS-1:0] ce;
  logic                running;

  modport master (
    output cfg_we, cfg_sel, cfg_inc, cfg_phase, resync,
    input  ce, running
  );

  modport slave (
    input  cfg_we, cfg_sel, cfg_inc, cfg_phase, resync,
    output ce, running
  );
endinterface

// File: rtl/clk_enable_gen.sv
// Multi-channel fractional clock-enable generator: per-channel phase accumulators
// that only run after the PLL lock has been synchronised and held for LOCK_CYCLES.
module clk_enable_gen #(
  parameter int               CHANNELS    = 4,
  parameter int               ACC_W       = 32,
  parameter int               LOCK_CYCLES = 1024,
  parameter logic [ACC_W-1:0] DEFAULT_INC = {ACC_W{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_locked,
  clk_enable_gen_if.slave  bus
);
  localparam int              CNT_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t              state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                sync1_r;
  logic                lock_r;
  logic                running_r;
  logic [CHANNELS-1:0] ce_r;
  logic [ACC_W-1:0]    acc_r   [CHANNELS];
  logic [ACC_W-1:0]    inc_r   [CHANNELS];
  logic [ACC_W-1:0]    phase_r [CHANNELS];
  logic [ACC_W:0]      sum_s   [CHANNELS];
  logic                sel_ok_s;

  assign sel_ok_s    = (int'(bus.cfg_sel) < CHANNELS);
  assign bus.ce      = ce_r;
  assign bus.running = running_r;

  // Two-flop synchroniser for the asynchronous PLL lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      lock_r  <= 1'b0;
    end else begin
      sync1_r <= pll_locked;
      lock_r  <= sync1_r;
    end
  end

  // Per-channel increment and start-phase registers, writable in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        inc_r[i]   <= DEFAULT_INC;
        phase_r[i] <= {ACC_W{1'b0}};
      end
    end else if (bus.cfg_we && sel_ok_s) begin
      inc_r[bus.cfg_sel]   <= bus.cfg_inc;
      phase_r[bus.cfg_sel] <= bus.cfg_phase;
    end
  end

  // Next accumulator value with the carry kept as the top bit.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      sum_s[i] = {1'b0, acc_r[i]} + {1'b0, inc_r[i]};
    end
  end

  // Lock-qualification FSM and accumulator datapath; lock loss outranks resync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= WAIT_LOCK;
      cnt_r     <= {CNT_W{1'b0}};
      running_r <= 1'b0;
      ce_r      <= {CHANNELS{1'b0}};
      for (int i = 0; i < CHANNELS; i++) acc_r[i] <= {ACC_W{1'b0}};
    end else begin
      case (state_r)
        WAIT_LOCK: begin
          cnt_r     <= {CNT_W{1'b0}};
          running_r <= 1'b0;
          ce_r      <= {CHANNELS{1'b0}};
          for (int i = 0; i < CHANNELS; i++) acc_r[i] <= {ACC_W{1'b0}};
          state_r   <= lock_r ? SETTLE : WAIT_LOCK;
        end
        SETTLE: begin
          ce_r <= {CHANNELS{1'b0}};
          if (!lock_r) begin
            state_r <= WAIT_LOCK;
            cnt_r   <= {CNT_W{1'b0}};
          end else if (cnt_r == CNT_LAST) begin
            state_r   <= RUN;
            cnt_r     <= {CNT_W{1'b0}};
            running_r <= 1'b1;
            for (int i = 0; i < CHANNELS; i++) acc_r[i] <= phase_r[i];
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        RUN: begin
          if (!lock_r) begin
            state_r   <= WAIT_LOCK;
            running_r <= 1'b0;
            ce_r      <= {CHANNELS{1'b0}};
            for (int i = 0; i < CHANNELS; i++) acc_r[i] <= {ACC_W{1'b0}};
          end else if (bus.resync) begin
            ce_r <= {CHANNELS{1'b0}};
            for (int i = 0; i < CHANNELS; i++) acc_r[i] <= phase_r[i];
          end else begin
            for (int i = 0; i < CHANNELS; i++) begin
              acc_r[i] <= sum_s[i][ACC_W-1:0];
              ce_r[i]  <= sum_s[i][ACC_W];
            end
          end
        end
        default: begin
          state_r   <= WAIT_LOCK;
          cnt_r     <= {CNT_W{1'b0}};
          running_r <= 1'b0;
          ce_r      <= {CHANNELS{1'b0}};
          for (int i = 0; i < CHANNELS; i++) acc_r[i] <= {ACC_W{1'b0}};
        end
      endcase
    end
  end
endmodule

// File: tb/tb_clk_enable_gen.sv
// Self-checking bench for clk_enable_gen: directed timing scenarios plus randomized
// traffic, compared against a cycle model built on lock-streak counting and 64-bit sums.
module tb_clk_enable_gen;
  localparam int CH = 4;
  localparam int AW = 32;
  localparam int L  = 4;
  localparam longint unsigned MODV = 64'h1_0000_0000;

  logic clk;
  logic rst_n;
  logic pll_locked;
  int   checks;
  int   errors;

  clk_enable_gen_if #(.CHANNELS(CH), .ACC_W(AW)) bus ();

  clk_enable_gen #(
    .CHANNELS(CH), .ACC_W(AW), .LOCK_CYCLES(L), .DEFAULT_INC(32'h0000_0000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: lock history, length of the current synchronised-lock streak,
  // and per-channel accumulators kept as plain integers.
  bit              m_s1, m_s2;
  int              m_streak;
  longint unsigned m_acc [CH];
  longint unsigned m_inc [CH];
  longint unsigned m_phase [CH];
  logic [CH-1:0]   m_ce;
  logic            m_run;

  task automatic model_reset();
    m_s1 = 1'b0; m_s2 = 1'b0; m_streak = 0; m_ce = '0; m_run = 1'b0;
    for (int i = 0; i < CH; i++) begin
      m_acc[i] = 0; m_inc[i] = 0; m_phase[i] = 0;
    end
  endtask

  task automatic tick();
    longint unsigned sum;
    if (!m_s2) begin
      m_streak = 0; m_run = 1'b0; m_ce = '0;
      for (int i = 0; i < CH; i++) m_acc[i] = 0;
    end else begin
      m_streak++;
      if (m_streak == L + 1) begin
        m_run = 1'b1; m_ce = '0;
        for (int i = 0; i < CH; i++) m_acc[i] = m_phase[i];
      end else if (m_streak > L + 1) begin
        if (bus.resync) begin
          m_ce = '0;
          for (int i = 0; i < CH; i++) m_acc[i] = m_phase[i];
        end else begin
          for (int i = 0; i < CH; i++) begin
            sum      = m_acc[i] + m_inc[i];
            m_ce[i]  = (sum >= MODV);
            m_acc[i] = sum % MODV;
          end
        end
      end else begin
        m_ce = '0;
      end
    end
    if (bus.cfg_we) begin
      m_inc[int'(bus.cfg_sel)]   = longint'(bus.cfg_inc);
      m_phase[int'(bus.cfg_sel)] = longint'(bus.cfg_phase);
    end
    m_s2 = m_s1;
    m_s1 = pll_locked;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int sel, input logic [31:0] inc, input logic [31:0] ph);
    bus.cfg_we = 1'b1; bus.cfg_sel = 2'(sel); bus.cfg_inc = inc; bus.cfg_phase = ph;
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.ce !== 4'b0000) begin
      errors++; $display("FAIL reset_ce: got %b want 0000", bus.ce);
    end
    checks++;
    if (bus.running !== 1'b0) begin
      errors++; $display("FAIL reset_running: got %b want 0", bus.running);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (bus.running !== 1'b0 || bus.ce !== 4'b0000) begin
        errors++; $display("FAIL idle_unlocked: running=%b ce=%b want 0/0000", bus.running, bus.ce);
      end
    end
  endtask

  task automatic test_lock_and_rates();
    int first_run, first0, first1, cnt2, cnt3;
    first_run = -1; first0 = -1; first1 = -1; cnt2 = 0; cnt3 = 0;
    cfg_write(0, 32'h8000_0000, 32'h0000_0000);
    cfg_write(1, 32'h8000_0000, 32'h8000_0000);
    cfg_write(2, 32'h4000_0000, 32'h0000_0000);
    cfg_write(3, 32'h0000_0000, 32'h0000_0000);
    pll_locked = 1'b1;
    for (int e = 0; e < 1007; e++) begin
      tick();
      checks++;
      if (bus.ce !== m_ce || bus.running !== m_run) begin
        errors++;
        $display("FAIL rates_model e=%0d: ce=%b run=%b want ce=%b run=%b", e, bus.ce, bus.running, m_ce, m_run);
      end
      if (bus.running === 1'b1 && first_run < 0) first_run = e;
      if (bus.ce[0] === 1'b1 && first0 < 0) first0 = e;
      if (bus.ce[1] === 1'b1 && first1 < 0) first1 = e;
      if (e >= 7) begin
        if (bus.ce[2] === 1'b1) cnt2++;
        if (bus.ce[3] === 1'b1) cnt3++;
      end
    end
    checks++;
    if (first_run != 6) begin errors++; $display("FAIL first_running: edge %0d want 6", first_run); end
    checks++;
    if (first0 != 8) begin errors++; $display("FAIL first_ce0: edge %0d want 8", first0); end
    checks++;
    if (first1 != 7) begin errors++; $display("FAIL first_ce1: edge %0d want 7", first1); end
    checks++;
    if (cnt2 != 250) begin errors++; $display("FAIL ce2_count: got %0d want 250", cnt2); end
    checks++;
    if (cnt3 != 0) begin errors++; $display("FAIL ce3_count: got %0d want 0", cnt3); end
  endtask

  task automatic test_settle_drop();
    int first_run;
    first_run = -1;
    pll_locked = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    for (int e = 0; e < 20; e++) begin
      pll_locked = (e == 3 || e == 4) ? 1'b0 : 1'b1;
      tick();
      checks++;
      if (bus.ce !== m_ce || bus.running !== m_run) begin
        errors++;
        $display("FAIL settle_model e=%0d: ce=%b run=%b want ce=%b run=%b", e, bus.ce, bus.running, m_ce, m_run);
      end
      if (bus.running === 1'b1 && first_run < 0) first_run = e;
    end
    checks++;
    if (first_run != 11) begin errors++; $display("FAIL settle_restart: running at edge %0d want 11", first_run); end
  endtask

  task automatic test_run_drop();
    int first0, first1;
    first0 = -1; first1 = -1;
    pll_locked = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.running !== 1'b1) begin errors++; $display("FAIL drop_edge1_running: got %b want 1", bus.running); end
    tick();
    checks++;
    if (bus.running !== 1'b0 || bus.ce !== 4'b0000) begin
      errors++; $display("FAIL drop_edge2: running=%b ce=%b want 0/0000", bus.running, bus.ce);
    end
    for (int k = 0; k < 3; k++) tick();
    pll_locked = 1'b1;
    for (int e = 0; e < 30; e++) begin
      tick();
      checks++;
      if (bus.ce !== m_ce || bus.running !== m_run) begin
        errors++;
        $display("FAIL relock_model e=%0d: ce=%b run=%b want ce=%b run=%b", e, bus.ce, bus.running, m_ce, m_run);
      end
      if (bus.ce[0] === 1'b1 && first0 < 0) first0 = e;
      if (bus.ce[1] === 1'b1 && first1 < 0) first1 = e;
    end
    checks++;
    if (first0 != 8 || first1 != 7) begin
      errors++; $display("FAIL relock_phase: ce0 at %0d ce1 at %0d want 8 and 7", first0, first1);
    end
  endtask

  task automatic test_resync();
    int first_a, first_b;
    first_a = -1; first_b = -1;
    bus.resync = 1'b1;
    bus.cfg_we = 1'b1; bus.cfg_sel = 2'd0; bus.cfg_inc = 32'h8000_0000; bus.cfg_phase = 32'h8000_0000;
    tick();
    bus.resync = 1'b0; bus.cfg_we = 1'b0;
    checks++;
    if (bus.ce !== 4'b0000) begin errors++; $display("FAIL resync_ce_clear: got %b want 0000", bus.ce); end
    for (int e = 1; e < 10; e++) begin
      tick();
      checks++;
      if (bus.ce !== m_ce) begin errors++; $display("FAIL resync_a_model e=%0d: got %b want %b", e, bus.ce, m_ce); end
      if (bus.ce[0] === 1'b1 && first_a < 0) first_a = e;
    end
    bus.resync = 1'b1;
    tick();
    bus.resync = 1'b0;
    for (int e = 1; e < 10; e++) begin
      tick();
      checks++;
      if (bus.ce !== m_ce) begin errors++; $display("FAIL resync_b_model e=%0d: got %b want %b", e, bus.ce, m_ce); end
      if (bus.ce[0] === 1'b1 && first_b < 0) first_b = e;
    end
    checks++;
    if (first_a != 2) begin errors++; $display("FAIL resync_old_phase: ce0 at %0d want 2", first_a); end
    checks++;
    if (first_b != 1) begin errors++; $display("FAIL resync_new_phase: ce0 at %0d want 1", first_b); end
  endtask

  task automatic test_random();
    int low_left;
    int pick;
    low_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (low_left > 0) begin
        pll_locked = 1'b0; low_left--;
      end else begin
        pll_locked = 1'b1;
        if ($urandom_range(0, 299) == 0) low_left = $urandom_range(1, 8);
      end
      bus.cfg_we    = ($urandom_range(0, 7) == 0);
      bus.cfg_sel   = 2'($urandom_range(0, 3));
      pick          = $urandom_range(0, 4);
      bus.cfg_inc   = (pick == 0) ? 32'h0000_0000 :
                      (pick == 1) ? 32'hFFFF_FFFF :
                      (pick == 2) ? (32'($urandom) >> 4) : 32'($urandom);
      bus.cfg_phase = 32'($urandom);
      bus.resync    = ($urandom_range(0, 39) == 0);
      tick();
      checks++;
      if (bus.ce !== m_ce || bus.running !== m_run) begin
        errors++;
        $display("FAIL random_model c=%0d: ce=%b run=%b want ce=%b run=%b", c, bus.ce, bus.running, m_ce, m_run);
      end
    end
    bus.cfg_we = 1'b0; bus.resync = 1'b0;
  endtask

  task automatic test_async_reset();
    int first_run;
    first_run = -1;
    pll_locked = 1'b1;
    for (int k = 0; k < 12; k++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (bus.ce !== 4'b0000 || bus.running !== 1'b0) begin
      errors++; $display("FAIL async_reset: ce=%b running=%b want 0000/0", bus.ce, bus.running);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 0; e < 40; e++) begin
      tick();
      checks++;
      if (bus.ce !== m_ce || bus.running !== m_run) begin
        errors++;
        $display("FAIL post_reset_model e=%0d: ce=%b run=%b want ce=%b run=%b", e, bus.ce, bus.running, m_ce, m_run);
      end
      checks++;
      if (bus.ce !== 4'b0000) begin errors++; $display("FAIL post_reset_inc_default e=%0d: ce=%b want 0000", e, bus.ce); end
      if (bus.running === 1'b1 && first_run < 0) first_run = e;
    end
    checks++;
    if (first_run != 6) begin errors++; $display("FAIL post_reset_running: edge %0d want 6", first_run); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; pll_locked = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_sel = 2'd0; bus.cfg_inc = 32'h0000_0000;
    bus.cfg_phase = 32'h0000_0000; bus.resync = 1'b0;
    model_reset();
    #12;
    test_reset();
    test_lock_and_rates();
    test_settle_drop();
    test_run_drop();
    test_resync();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/clk_enable_gen.md
# clk_enable_gen

Parametrised multi-channel fractional clock-enable generator. It sits downstream of the core PLL wrapper and replaces a growing list of fixed PLL output taps with synchronous clock-enable pulses derived from one fast clock. Each channel is a phase accumulator with a runtime-programmable increment and start phase. The block also gates all channels on a debounced, synchronised PLL lock and provides a global phase-realign.

## Interface
- CHANNELS, 4: number of enable channels (1..16)
- ACC_W, 32: accumulator width; channel rate = f_clk * inc / 2^ACC_W
- LOCK_CYCLES, 1024: cycles the synchronised lock must stay high before enables start (>=1)
- DEFAULT_INC, 32'h0000_0000: reset increment for every channel (ACC_W bits)
- clk  in  1  fast system clock (PLL output)
- rst_n  in  1  asynchronous active-low reset
- pll_locked  in  1  asynchronous lock from the PLL
- cfg_we  in  1  write strobe, one cycle per write
- cfg_sel  in  $clog2(CHANNELS) (min 1)  channel index
- cfg_inc  in  ACC_W  new increment for the channel
- cfg_phase  in  ACC_W  new start phase for the channel
- resync  in  1  single-cycle pulse; realigns all accumulators to their phases
- ce  out  CHANNELS  per-channel enable pulses, one clk wide
- running  out  1  high while the state is RUN

## Operation
- Lock synchroniser: two flops, lock_s = second flop, reset 0.
- FSM states are WAIT_LOCK (reset state), SETTLE and RUN.
  - WAIT_LOCK: counter = 0, acc = 0, ce = 0. lock_s = 1 -> SETTLE.
  - SETTLE: counter increments each cycle. lock_s = 0 -> WAIT_LOCK. counter == LOCK_CYCLES-1 -> RUN, load acc[i] = phase[i], counter = 0.
  - RUN: each cycle {carry, acc[i]} = acc[i] + inc[i] (ACC_W+1-bit sum, wraps modulo 2^ACC_W). ce[i] <= carry. lock_s = 0 -> WAIT_LOCK, ce <= 0 on that edge.
- resync in RUN: acc[i] <= phase[i] for all i, ce <= 0 that edge, no accumulation that cycle. resync outside RUN is ignored.
- Config write (cfg_we = 1):
  - inc[cfg_sel] and phase[cfg_sel] update at the edge.
  - The new inc is used from the next accumulation.
  - The new phase applies only at the next SETTLE->RUN load or resync.
  - cfg_sel >= CHANNELS is ignored.
  - Writes are accepted in every state.
- Simultaneous events:
  - Lock loss wins over resync.
  - A cfg write on the same edge as resync: resync uses the old phase, and the register takes the new value.
- inc = 0: the channel never fires.
- inc = 2^ACC_W-1: the channel fires every cycle except one per 2^ACC_W.
- Reset values: ce = 0, running = 0, state WAIT_LOCK, acc = 0, inc = DEFAULT_INC, phase = 0, counter = 0, sync flops = 0.
- Async reset mid-operation returns every register to its reset value immediately, including cfg registers.

## Timing
- pll_locked rising, sampled at edge 0:
  - lock_s = 1 after edge 1.
  - SETTLE after edge 2.
  - RUN (running = 1) after edge 2+LOCK_CYCLES.
- First accumulation happens at edge 3+LOCK_CYCLES. ce is registered, so a carry produced at edge n shows as ce high during cycle n..n+1.
- pll_locked falling at edge 0 -> WAIT_LOCK and ce = 0 after edge 2. A lock glitch shorter than one cycle may be missed. Any lock drop seen in SETTLE restarts the count.
- Config-to-effect latency is 1 edge. resync-to-realigned acc is 1 edge.
- All outputs are registered; there is no combinational path from input to output.

## Test plan
- CHANNELS=4, ACC_W=32, LOCK_CYCLES=4, ch0 inc=32'h8000_0000 phase=0, lock high at edge 0 -> running high after edge 6; ce[0] first high after edge 8, then every 2 cycles.
- Same setup, ch1 phase=32'h8000_0000 -> ce[1] first high after edge 7, alternating with ce[0].
- ch2 inc=32'h4000_0000 -> ce[2] exactly 1 in 4 cycles, 250 pulses over 1000 RUN cycles; ch3 inc=0 -> ce[3] never high.
- Lock dropped for 2 cycles during SETTLE, at counter=2 -> returns to WAIT_LOCK; running delayed by the full restart (2+LOCK_CYCLES edges after lock returns).
- In RUN, lock dropped -> ce all 0 and running 0 after 2 edges. Then lock restored -> outputs resume with phases reloaded.
- resync pulse together with a cfg write to ch0 phase=32'h8000_0000 -> realign uses phase 0. A second resync later uses 32'h8000_0000. ce[0] phase shift of one cycle is confirmed.
